// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_pkg
// Purpose  : Instruction encoding constants, fetch FSM states and queue entry
//            type shared by the fetch unit and the core.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

    localparam int          c_INSTR_W  = 32;
    localparam logic [31:0] c_NOP      = 32'h0000_0000;
    localparam int          c_OPC_MSB  = 31;
    localparam int          c_OPC_LSB  = 26;
    localparam logic [5:0]  c_OPC_ADD  = 6'b000001;
    localparam logic [5:0]  c_OPC_SW   = 6'b000010;
    localparam logic [5:0]  c_OPC_LW   = 6'b000100;
    localparam logic [31:0] c_PC_INC   = 32'd4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]          pc;
        logic [c_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [5:0] opcode_of(input logic [c_INSTR_W-1:0] instr);
        return instr[c_OPC_MSB:c_OPC_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Purpose  : Fetch-to-core instruction handshake plus the core's PC redirect.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic                 instr_valid;
    logic                 instr_ready;
    logic [c_INSTR_W-1:0] instruction;
    logic [31:0]          instr_pc;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;

    modport master (
        output instr_valid,
        output instruction,
        output instr_pc,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  instr_valid,
        input  instruction,
        input  instr_pc,
        output instr_ready,
        output redirect_valid,
        output redirect_pc
    );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Power-of-two FIFO of {pc, instruction} with synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         push,
    input  wire fetch_entry_t push_data,
    input  wire logic         pop,
    input  wire logic         flush,
    output fetch_entry_t      head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        end
    end

    // Storage needs no reset: every slot is written before count exposes it.
    always_ff @(posedge clk) begin
        if (w_push_ok && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : PC, instruction memory and prefetch queue feeding the core.
//            Define FETCH_PERF_CNT_EN to add perf_fetched/perf_stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              fetch_en,
    input  wire logic              imem_we,
    input  wire logic [ADDR_W-1:0] imem_waddr,
    input  wire logic [31:0]       imem_wdata,
    instr_fetch_unit_if.master     fetch_bus,
    output logic [31:0]            fetch_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_stall
`endif
);

    localparam int c_MEM_WORDS = 2 ** ADDR_W;
    localparam int c_CNT_W     = $clog2(DEPTH) + 1;

    fetch_state_e         r_state;
    fetch_state_e         w_next_state;
    logic [31:0]          r_pc;
    logic [31:0]          r_rd_pc;
    logic [c_INSTR_W-1:0] r_rd_data;
    logic                 r_rd_valid;
    logic [c_INSTR_W-1:0] r_imem [c_MEM_WORDS];

    logic                 w_issue;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_redirect;
    logic                 w_room;
    logic                 w_full;
    logic                 w_empty;
    logic [c_CNT_W-1:0]   w_count;
    logic [c_CNT_W:0]     w_occ;
    logic [ADDR_W-1:0]    w_rd_idx;
    fetch_entry_t         w_push_entry;
    fetch_entry_t         w_head;
    logic                 w_unused;

    assign w_redirect = fetch_bus.redirect_valid;
    assign w_pop      = !w_empty && fetch_bus.instr_ready;
    assign w_push     = r_rd_valid && !w_redirect;
    assign w_rd_idx   = r_pc[ADDR_W+1:2];

    // The in-flight read already owns a queue slot, so it can never overflow.
    assign w_occ  = (c_CNT_W+1)'(w_count) + (c_CNT_W+1)'(r_rd_valid)
                  - (c_CNT_W+1)'(w_pop);
    assign w_room = (w_occ < (c_CNT_W+1)'(DEPTH));

    // Issue is gated by the state being entered at this edge so the first
    // read launches in the same cycle fetch_en rises.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: if (fetch_en)  w_next_state = ST_RUN;
            ST_RUN:  if (!fetch_en) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        if ((w_next_state == ST_RUN) && w_room && !w_redirect) begin
            w_issue = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_rd_valid <= 1'b0;
            r_rd_pc    <= '0;
        end else begin
            r_state    <= w_next_state;
            r_rd_valid <= w_issue;
            if (w_redirect) begin
                r_pc <= {fetch_bus.redirect_pc[31:2], 2'b00};
            end else if (w_issue) begin
                r_pc    <= r_pc + c_PC_INC;
                r_rd_pc <= r_pc;
            end
        end
    end

    // Read-before-write: a same-index read returns the previous contents.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_imem[imem_waddr] <= imem_wdata;
        end
        if (w_issue) begin
            r_rd_data <= r_imem[w_rd_idx];
        end
    end

    assign w_push_entry.pc    = r_rd_pc;
    assign w_push_entry.instr = r_rd_data;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (w_redirect),
        .head_data (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign fetch_bus.instr_valid = !w_empty;
    assign fetch_bus.instruction = w_empty ? c_NOP : w_head.instr;
    assign fetch_bus.instr_pc    = w_empty ? 32'h0 : w_head.pc;
    assign fetch_pc              = r_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (fetch_bus.instr_ready && w_empty) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

    assign w_unused = ^{fetch_bus.redirect_pc[1:0], w_full};

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed vector table, async-reset sequence and randomized run of
//            instr_fetch_unit against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int          ADDR_W   = 8;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] I0 = 32'h0443_0800;
    localparam logic [31:0] I1 = 32'h0841_0000;
    localparam logic [31:0] I2 = 32'h1044_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              fetch_en;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic [31:0]       fetch_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_stall;
`endif

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .fetch_bus    (bus),
        .fetch_pc     (fetch_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of fetched words plus one pending read.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_inf;
    bit          m_inf_v;
    logic [31:0] m_pc;
    logic [31:0] m_mem [2**ADDR_W];
    int unsigned m_fetched;
    int unsigned m_stall;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [31:0] efpc;
    } vec_t;

    vec_t tbl [19];

    task automatic model_reset();
        mq.delete();
        m_inf_v   = 1'b0;
        m_pc      = RESET_PC;
        m_fetched = 0;
        m_stall   = 0;
    endtask

    task automatic model_edge();
        bit pop;
        int occ;
        pop = (mq.size() != 0) && bus.instr_ready;
        if (bus.instr_ready && mq.size() == 0) m_stall++;
        if (pop) m_fetched++;
        if (bus.redirect_valid) begin
            mq.delete();
            m_inf_v = 1'b0;
            m_pc    = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            occ = mq.size() + int'(m_inf_v) - int'(pop);
            if (pop) void'(mq.pop_front());
            if (m_inf_v) mq.push_back(m_inf);
            if (fetch_en && occ < DEPTH) begin
                m_inf.pc    = m_pc;
                m_inf.instr = m_mem[m_pc[ADDR_W+1:2]];
                m_inf_v     = 1'b1;
                m_pc        = m_pc + 32'd4;
            end else begin
                m_inf_v = 1'b0;
            end
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic ev, input logic [31:0] ei,
                         input logic [31:0] ep, input logic [31:0] efpc);
        n_checks++;
        if (bus.instr_valid === ev && bus.instruction === ei &&
            bus.instr_pc === ep && fetch_pc === efpc) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got valid=%0b instr=%h pc=%h fetch_pc=%h, expected valid=%0b instr=%h pc=%h fetch_pc=%h",
                     name, bus.instr_valid, bus.instruction, bus.instr_pc, fetch_pc,
                     ev, ei, ep, efpc);
        end
    endtask

    task automatic check_model(input string name);
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        ev = (mq.size() != 0);
        ei = ev ? mq[0].instr : 32'h0;
        ep = ev ? mq[0].pc    : 32'h0;
        check(name, ev, ei, ep, m_pc);
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic check_perf(input string name, input logic [31:0] ef, input logic [31:0] es);
        n_checks++;
        if (perf_fetched === ef && perf_stall === es) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got fetched=%0d stall=%0d, expected fetched=%0d stall=%0d",
                     name, perf_fetched, perf_stall, ef, es);
        end
    endtask
`endif

    initial begin
        fetch_en           = 1'b0;
        imem_we            = 1'b0;
        imem_waddr         = '0;
        imem_wdata         = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        model_reset();

        //         en    rdy   rv    rpc          ev    instr         pc          fetch_pc
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,        32'h0,      32'h4};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b1, I0,           32'h0,      32'h8};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b1, I0,           32'h0,      32'h8};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b1, I0,           32'h0,      32'h8};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b1, I0,           32'h0,      32'h8};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b1, I1,           32'h4,      32'hC};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b1, I2,           32'h8,      32'h10};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 32'hA500_0003, 32'hC,     32'h14};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 32'hA500_0003, 32'hC,     32'h14};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h40,    1'b0, 32'h0,        32'h0,      32'h40};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        32'h0,      32'h44};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 32'hA500_0010, 32'h40,    32'h48};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h3FC,   1'b0, 32'h0,        32'h0,      32'h3FC};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        32'h0,      32'h400};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 32'hA500_00FF, 32'h3FC,   32'h404};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b1, I0,           32'h400,    32'h408};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, I0,           32'h400,    32'h408};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b1, I1,           32'h404,    32'h408};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        32'h0,      32'h408};

        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset", 1'b0, 32'h0, 32'h0, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
        check_perf("perf_reset", 32'd0, 32'd0);
`endif
        rst = 1'b0;

        // Program load with fetch disabled.
        for (int i = 0; i < 2**ADDR_W; i++) begin
            imem_we    = 1'b1;
            imem_waddr = i[ADDR_W-1:0];
            imem_wdata = (i == 0) ? I0 : (i == 1) ? I1 : (i == 2) ? I2
                                   : (32'hA500_0000 | i[31:0]);
            step();
        end
        imem_we = 1'b0;
        model_reset();
        check_model("idle_after_load");

        for (int i = 0; i < 19; i++) begin
            fetch_en           = tbl[i].en;
            bus.instr_ready    = tbl[i].rdy;
            bus.redirect_valid = tbl[i].rv;
            bus.redirect_pc    = tbl[i].rpc;
            step();
            check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].efpc);
        end
        bus.redirect_valid = 1'b0;

        // Fill the queue, then hit reset between clock edges.
        fetch_en        = 1'b1;
        bus.instr_ready = 1'b0;
        repeat (3) step();
        @(posedge clk);
        model_edge();
        #2 rst = 1'b1;
        #1 check("async_rst", 1'b0, 32'h0, 32'h0, RESET_PC);
        model_reset();
        @(negedge clk);
        rst             = 1'b0;
        bus.instr_ready = 1'b1;
        step();
        check("restart_e1", 1'b0, 32'h0, 32'h0, 32'h4);
        step();
        check("restart_e2", 1'b1, I0, 32'h0, 32'h8);
        step();
        check("restart_e3", 1'b1, I1, 32'h4, 32'hC);
        step();
        step();
        check_model("restart_e5");
`ifdef FETCH_PERF_CNT_EN
        check_perf("perf_3pop_2stall", 32'd3, 32'd2);
`endif

        for (int i = 0; i < 600; i++) begin
            fetch_en           = ($urandom_range(0, 9) != 0);
            bus.instr_ready    = ($urandom_range(0, 2) != 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc    = $urandom();
            imem_we            = ($urandom_range(0, 5) == 0);
            imem_waddr         = ($urandom_range(0, 1) == 0) ? m_pc[ADDR_W+1:2]
                                                             : ADDR_W'($urandom());
            imem_wdata         = $urandom();
            step();
            check_model($sformatf("rand%0d", i));
`ifdef FETCH_PERF_CNT_EN
            check_perf($sformatf("perf_rand%0d", i), m_fetched, m_stall);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the single-cycle processor core.
- Holds the PC and a word-addressed instruction memory with 1-cycle synchronous read.
- Buffers fetched words in a small prefetch queue and presents them to the core's 32-bit instruction input through a valid/ready handshake.
- Accepts PC redirects (branch/jump) from the core, flushing stale fetches.

Parameters:
- ADDR_W, 8, instruction-memory index width; MEM_WORDS = 2**ADDR_W.
- DEPTH, 2, prefetch queue entries; must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset; byte address, word aligned.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  high lets new fetches issue; low freezes PC, queue still drains.
- imem_we  in  1  instruction-memory write strobe (program load).
- imem_waddr  in  ADDR_W  write word index.
- imem_wdata  in  32  write data.
- redirect_valid  in  1  PC redirect request.
- redirect_pc  in  32  redirect target, byte address; bits [1:0] ignored.
- instr_ready  in  1  core accepts the head instruction this cycle.
- instr_valid  out  1  head of queue is valid.
- instruction  out  32  head instruction; 32'h0 (NOP) whenever instr_valid is 0.
- instr_pc  out  32  PC of the head instruction; 0 when invalid.
- fetch_pc  out  32  PC of the next fetch to issue.

Behaviour:
- Reset (asynchronous, active-high):
  - pc = RESET_PC; queue empty; in-flight flag cleared.
  - instr_valid = 0, instruction = 0, instr_pc = 0, fetch_pc = RESET_PC.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards the queue and any in-flight read immediately.
- FSM states:
  - IDLE: after reset and while fetch_en = 0; no fetch issues. Moves to RUN when fetch_en = 1.
  - RUN: issues fetches. Moves to IDLE when fetch_en = 0; an already issued read still completes into the queue.
- Issue rule:
  - A fetch issues in a cycle when state = RUN and (count + inflight − pop) < DEPTH.
  - Issue reads mem[pc[ADDR_W+1:2]], then pc += 4 (32-bit wrap). The memory index wraps modulo MEM_WORDS.
- Latency:
  - Read data and its PC are pushed into the queue on the next edge.
  - The first instruction after reset with fetch_en = 1 from cycle 0 is valid at edge 2.
  - Steady-state throughput with instr_ready = 1 is 1 instruction per cycle.
- Handshake:
  - Pop occurs when instr_valid && instr_ready.
  - instruction and instr_pc hold stable while instr_valid = 1 and instr_ready = 0.
  - Push and pop in the same cycle leave count unchanged.
- Full: count = DEPTH blocks issue. An in-flight read never overflows, because the issue rule counts it.
- Empty: instr_valid = 0 and instruction = 0. There is no bypass; a pushed word is visible the cycle after the push.
- Redirect (redirect_valid = 1 at an edge):
  - Queue is cleared.
  - The in-flight read is marked killed; its data is dropped on arrival.
  - pc = {redirect_pc[31:2], 2'b00}.
  - No issue occurs in the redirect cycle.
  - Redirect wins over simultaneous issue, push and pop. A simultaneous pop counts as accepted by the core, but the queue is still cleared.
  - The first target instruction is valid 2 cycles after the redirect edge.
- Memory write:
  - imem_we writes on the edge.
  - A read of the same index in the same cycle returns the old data.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_fetched (32): count of instructions popped.
  - perf_stall (32): count of cycles with instr_ready = 1 and instr_valid = 0.
- Both counters reset to 0 and wrap at 2^32.
- When not defined, neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package/header: instruction width (32), NOP encoding (32'h0), opcode field position [31:26] with codes ADD = 6'b000001, SW = 6'b000010, LW = 6'b000100, PC increment (4). The same definitions are used by the core.
- One sub-module: fetch_queue, a parameterised synchronous FIFO of {pc, instruction} with push, pop, flush, count, full and empty.
- PC, FSM, memory and redirect logic stay in instr_fetch_unit.

Test Plan:
- Reset then load mem[0..2] = add 32'h0443_0800, sw 32'h0841_0000, lw 32'h1044_0000; fetch_en = 1, instr_ready = 1. Required: the three words appear on consecutive cycles with instr_pc 0, 4, 8; first valid at edge 2.
- Backpressure: hold instr_ready = 0 for 5 cycles. Required: count saturates at DEPTH = 2; fetch_pc stops at 8; instruction stays 32'h0443_0800. Release: in-order delivery with no loss or duplicate.
- Redirect: redirect_valid with redirect_pc = 32'h40 while the queue is full. Required: instr_valid drops next cycle; the first valid output is mem[16] with instr_pc 32'h40, 2 cycles after the redirect.
- Wrap-around: redirect to 32'h3FC (index 255). Required: next instr_pc 32'h400, fetching from index 0.
- Asynchronous reset asserted mid-stream, between edges. Required: outputs are immediately instr_valid = 0, instruction = 0, fetch_pc = RESET_PC; fetch restarts from 0 after deassertion.
- FETCH_PERF_CNT_EN defined: 3 pops plus 2 starved-ready cycles → perf_fetched = 3, perf_stall = 2.
